// File: rtl/freq_tuning_word.sv
// Frequency (Hz) to DDS phase increment converter: phase_inc = round(freq * 2^32 / 100 MHz).
// A serial shift-add multiply against a fixed scale constant runs only when freq_in changes.
module freq_tuning_word #(
    parameter int unsigned FREQ_W   = 20,
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned TW_SCALE = 2814750,
    parameter int unsigned TW_SHIFT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [FREQ_W-1:0]  freq_in,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               phase_inc_valid,
    output logic               busy
);

    localparam int unsigned SCALE_W = 22;
    localparam int unsigned ACC_W   = FREQ_W + SCALE_W;
    localparam int unsigned CNT_W   = $clog2(FREQ_W);

    localparam logic [ACC_W-1:0] SCALE_EXT  = ACC_W'(TW_SCALE);
    localparam logic [ACC_W:0]   ROUND_HALF = {{ACC_W{1'b0}}, 1'b1} << (TW_SHIFT - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FREQ_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [FREQ_W-1:0]    op_q, op_d;
    logic [FREQ_W-1:0]    last_freq_q, last_freq_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 force_q, force_d;
    logic [PHASE_W-1:0]   phase_inc_q, phase_inc_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic [ACC_W:0]       rnd_sum_s;
    logic [ACC_W:0]       rnd_shr_s;

    // Round half-up: add half an output LSB before dropping the fractional bits.
    assign rnd_sum_s = {1'b0, acc_q} + ROUND_HALF;
    assign rnd_shr_s = rnd_sum_s >> TW_SHIFT;

    // Next-state and datapath control for the IDLE/MULT/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        last_freq_d = last_freq_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        force_d     = force_q;
        phase_inc_d = phase_inc_q;
        valid_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && ((freq_in != last_freq_q) || force_q)) begin
                    op_d        = freq_in;
                    last_freq_d = freq_in;
                    acc_d       = '0;
                    bit_cnt_d   = '0;
                    force_d     = 1'b0;
                    state_d     = S_MULT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT: begin
                if (!enable) begin
                    force_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (op_q[bit_cnt_q]) begin
                        acc_d = acc_q + (SCALE_EXT << bit_cnt_q);
                    end else begin
                        acc_d = acc_q;
                    end
                    bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MULT;
                    end
                end
            end
            S_DONE: begin
                // An abort here still drops the result so a half-enabled update never leaks out.
                if (!enable) begin
                    force_d = 1'b1;
                end else begin
                    phase_inc_d = PHASE_W'(rnd_shr_s);
                    valid_d     = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            last_freq_q <= '0;
            acc_q       <= '0;
            bit_cnt_q   <= '0;
            force_q     <= 1'b1;
            phase_inc_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            last_freq_q <= last_freq_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            force_q     <= force_d;
            phase_inc_q <= phase_inc_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign phase_inc       = phase_inc_q;
    assign phase_inc_valid = valid_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_freq_tuning_word.sv
// Scoreboard bench for freq_tuning_word: stimulus pushes expected words and due cycles,
// a negedge monitor pops and compares on every phase_inc_valid pulse.
module tb_freq_tuning_word;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [19:0] freq_in;
    logic [31:0] phase_inc;
    logic        phase_inc_valid;
    logic        busy;

    typedef struct packed {
        logic [31:0] val;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cyc = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    freq_tuning_word dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .freq_in         (freq_in),
        .phase_inc       (phase_inc),
        .phase_inc_valid (phase_inc_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected word at its due cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && phase_inc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("phase_inc", {32'd0, phase_inc}, {32'd0, e.val});
                check("latency_cycle", {32'd0, cyc}, {32'd0, e.due});
            end
        end
    end

    // Call just after a posedge: the next posedge is E0, the result is visible after E0+21.
    task automatic push_exp(input logic [31:0] val, input logic [31:0] due);
        exp_t e;
        e.val = val;
        e.due = due;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [19:0] f, input logic [31:0] val);
        freq_in = f;
        push_exp(val, cyc + 32'd22);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 120) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", {32'd0, 32'(exp_q.size())}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        logic        changed;

        // Test 1: reset values, then first conversion after release.
        rst_n   = 1'b0;
        enable  = 1'b1;
        freq_in = 20'd100000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_phase_inc", {32'd0, phase_inc}, 64'd0);
        check("reset_valid", {63'd0, phase_inc_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        push_exp(32'd4294968, cyc + 32'd22);
        @(posedge clk);
        #1;
        check("busy_after_e0", {63'd0, busy}, 64'd1);
        drain();
        check("busy_idle", {63'd0, busy}, 64'd0);

        // Test 2: settled changes.
        apply(20'd1000, 32'd42950);
        drain();
        apply(20'd999000, 32'd42906727);
        drain();

        // Test 3: constant input, no further updates.
        held    = phase_inc;
        changed = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (phase_inc !== held || busy !== 1'b0) changed = 1'b1;
        end
        check("hold_stable", {63'd0, changed}, 64'd0);
        @(posedge clk);
        #1;

        // Test 4: change during MULT; the latched value completes, then the new one.
        // 300000 * 2814750 / 2^16 = 12884902.95..., which rounds half-up to 12884903.
        apply(20'd200000, 32'd8589935);
        begin
            logic [31:0] c0;
            c0 = cyc;
            repeat (5) @(posedge clk);
            #1;
            freq_in = 20'd300000;
            push_exp(32'd12884903, c0 + 32'd44);
        end
        drain();

        // Test 5: enable drop mid-conversion, then re-enable with the same input.
        held    = phase_inc;
        freq_in = 20'd1000;
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_phase_held", {32'd0, phase_inc}, {32'd0, held});
        check("abort_busy", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        push_exp(32'd42950, cyc + 32'd22);
        drain();

        // Test 6: reset mid-MULT, then force restarts a conversion of freq_in = 0.
        freq_in = 20'd1048575;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_phase", {32'd0, phase_inc}, 64'd0);
        check("async_reset_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        freq_in = 20'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(32'd0, cyc + 32'd22);
        drain();

        // Extremes of the input range.
        apply(20'd1048575, 32'd45035957);
        drain();
        apply(20'd1, 32'd43);
        drain();

        check("queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
